// File: rtl/bpb_set.sv
// ============================================================================
// Module   : bpb_set
// Brief    : One set of a WAYS-way branch prediction buffer with LRU ages.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bpb_set #(
    parameter int WAYS       = 4,
    parameter int TAG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int CTR_BITS   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      lk_en,
    input  logic [TAG_WIDTH-1:0]      lk_tag,
    output logic                      hit,
    output logic [$clog2(WAYS)-1:0]   hit_way,
    output logic                      pred_taken,
    output logic [ADDR_WIDTH-1:0]     pred_target,
    input  logic                      up_en,
    input  logic [TAG_WIDTH-1:0]      up_tag,
    input  logic                      up_taken,
    input  logic [ADDR_WIDTH-1:0]     up_target
);

    localparam int                   IDX_W    = $clog2(WAYS);
    localparam logic [CTR_BITS-1:0]  CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0]  CTR_WEAK = CTR_MAX ^ (CTR_MAX >> 1);
    localparam logic [IDX_W-1:0]     AGE_LRU  = IDX_W'(WAYS - 1);

    typedef logic [WAYS-1:0][IDX_W-1:0] age_vec_t;

    logic [WAYS-1:0]                  valid_q, valid_d;
    logic [WAYS-1:0][TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [WAYS-1:0][ADDR_WIDTH-1:0]  target_q, target_d;
    logic [WAYS-1:0][CTR_BITS-1:0]    ctr_q, ctr_d;
    age_vec_t                         age_q, age_d, age_mid;

    logic             up_hit;
    logic [IDX_W-1:0] up_way;
    logic             inv_found;
    logic [IDX_W-1:0] inv_way;
    logic [IDX_W-1:0] lru_way;
    logic [IDX_W-1:0] victim;

    // Promote way w to MRU; only ways younger than w age by one, so the
    // ages stay a permutation.
    function automatic age_vec_t touch(input age_vec_t a, input logic [IDX_W-1:0] w);
        age_vec_t r;
        r = a;
        for (int i = 0; i < WAYS; i++) begin
            if (a[i] < a[w]) begin
                r[i] = a[i] + 1'b1;
            end
        end
        r[w] = '0;
        return r;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (valid_q[i] && (tag_q[i] == lk_tag)) begin
                hit     = 1'b1;
                hit_way = IDX_W'(i);
            end
        end
        pred_taken  = hit & ctr_q[hit_way][CTR_BITS-1];
        pred_target = hit ? target_q[hit_way] : '0;
    end

    always_comb begin
        up_hit    = 1'b0;
        up_way    = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (valid_q[i] && (tag_q[i] == up_tag)) begin
                up_hit = 1'b1;
                up_way = IDX_W'(i);
            end
            if (age_q[i] == AGE_LRU) begin
                lru_way = IDX_W'(i);
            end
        end
        // Descending scan so the lowest-index invalid way is the last written.
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                inv_found = 1'b1;
                inv_way   = IDX_W'(i);
            end
        end
        victim = inv_found ? inv_way : lru_way;
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        age_mid  = age_q;
        age_d    = age_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            // Lookup touch lands first so a coinciding update ends up MRU.
            if (lk_en && hit) begin
                age_mid = touch(age_q, hit_way);
            end
            age_d = age_mid;
            if (up_en) begin
                if (up_hit) begin
                    if (up_taken) begin
                        if (ctr_q[up_way] != CTR_MAX) begin
                            ctr_d[up_way] = ctr_q[up_way] + 1'b1;
                        end
                        target_d[up_way] = up_target;
                    end else if (ctr_q[up_way] != '0) begin
                        ctr_d[up_way] = ctr_q[up_way] - 1'b1;
                    end
                    age_d = touch(age_mid, up_way);
                end else if (up_taken) begin
                    valid_d[victim]  = 1'b1;
                    tag_d[victim]    = up_tag;
                    target_d[victim] = up_target;
                    ctr_d[victim]    = CTR_WEAK;
                    age_d            = touch(age_mid, victim);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            tag_q    <= '0;
            target_q <= '0;
            ctr_q    <= '0;
            for (int i = 0; i < WAYS; i++) begin
                age_q[i] <= IDX_W'(i);
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
            age_q    <= age_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bpb_set.sv
// ============================================================================
// Module   : tb_bpb_set
// Brief    : Directed and random checks of bpb_set against a queue-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bpb_set;

    localparam int WAYS = 4;
    localparam int TW   = 8;
    localparam int AW   = 32;
    localparam int CB   = 2;

    logic          clk = 1'b0;
    logic          reset, flush, lk_en, up_en, up_taken;
    logic [TW-1:0] lk_tag, up_tag;
    logic [AW-1:0] up_target;
    logic          hit, pred_taken;
    logic [1:0]    hit_way;
    logic [AW-1:0] pred_target;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: recency kept as an ordered list of way indices, MRU first.
    bit            mv   [WAYS];
    logic [TW-1:0] mtag [WAYS];
    logic [AW-1:0] mtgt [WAYS];
    int            mctr [WAYS];
    int            order[$];

    always #5 clk = ~clk;

    bpb_set #(
        .WAYS       (WAYS),
        .TAG_WIDTH  (TW),
        .ADDR_WIDTH (AW),
        .CTR_BITS   (CB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .lk_en       (lk_en),
        .lk_tag      (lk_tag),
        .hit         (hit),
        .hit_way     (hit_way),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .up_en       (up_en),
        .up_tag      (up_tag),
        .up_taken    (up_taken),
        .up_target   (up_target)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic int mfind(input logic [TW-1:0] t);
        for (int i = 0; i < WAYS; i++) begin
            if (mv[i] && mtag[i] == t) return i;
        end
        return -1;
    endfunction

    task automatic mtouch(input int w);
        for (int k = 0; k < order.size(); k++) begin
            if (order[k] == w) begin
                order.delete(k);
                break;
            end
        end
        order.push_front(w);
    endtask

    task automatic mreset();
        order.delete();
        for (int i = 0; i < WAYS; i++) begin
            mv[i] = 1'b0; mtag[i] = '0; mtgt[i] = '0; mctr[i] = 0;
            order.push_back(i);
        end
    endtask

    task automatic mupdate();
        int lw, uw, victim;
        if (flush) begin
            for (int i = 0; i < WAYS; i++) mv[i] = 1'b0;
            return;
        end
        lw = mfind(lk_tag);
        uw = mfind(up_tag);
        victim = -1;
        for (int i = WAYS - 1; i >= 0; i--) if (!mv[i]) victim = i;
        if (victim < 0) victim = order[order.size() - 1];
        if (lk_en && lw >= 0) mtouch(lw);
        if (up_en) begin
            if (uw >= 0) begin
                if (up_taken) begin
                    mctr[uw] = (mctr[uw] + 1 > (1 << CB) - 1) ? (1 << CB) - 1 : mctr[uw] + 1;
                    mtgt[uw] = up_target;
                end else begin
                    mctr[uw] = (mctr[uw] > 0) ? mctr[uw] - 1 : 0;
                end
                mtouch(uw);
            end else if (up_taken) begin
                mv[victim]   = 1'b1;
                mtag[victim] = up_tag;
                mtgt[victim] = up_target;
                mctr[victim] = 1 << (CB - 1);
                mtouch(victim);
            end
        end
    endtask

    task automatic mcheck();
        int w;
        w = mfind(lk_tag);
        if (w < 0) begin
            chk("m_hit", 64'(hit), 64'(0));
            chk("m_hit_way", 64'(hit_way), 64'(0));
            chk("m_pred_taken", 64'(pred_taken), 64'(0));
            chk("m_pred_target", 64'(pred_target), 64'(0));
        end else begin
            chk("m_hit", 64'(hit), 64'(1));
            chk("m_hit_way", 64'(hit_way), 64'(w));
            chk("m_pred_taken", 64'(pred_taken), 64'(mctr[w] >= (1 << (CB - 1))));
            chk("m_pred_target", 64'(pred_target), 64'(mtgt[w]));
        end
    endtask

    task automatic drive(input bit fl, input bit lke, input logic [TW-1:0] lkt,
                         input bit upe, input logic [TW-1:0] upt, input bit tk,
                         input logic [AW-1:0] tgt);
        flush = fl; lk_en = lke; lk_tag = lkt;
        up_en = upe; up_tag = upt; up_taken = tk; up_target = tgt;
        #2;
    endtask

    task automatic step();
        mcheck();
        @(posedge clk);
        mupdate();
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; lk_en = 1'b0; lk_tag = '0;
        up_en = 1'b0; up_tag = '0; up_taken = 1'b0; up_target = '0;
        mreset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hit", 64'(hit), 64'(0));
        chk("rst_pred_target", 64'(pred_target), 64'(0));
        reset = 1'b0;

        drive(0, 1, 8'h00, 0, 8'h00, 0, 32'h0);
        chk("empty_hit", 64'(hit), 64'(0));
        chk("empty_way", 64'(hit_way), 64'(0));
        chk("empty_target", 64'(pred_target), 64'(0));
        step();

        drive(0, 0, 8'h00, 1, 8'h12, 1, 32'h400);
        step();
        drive(0, 1, 8'h12, 0, 8'h00, 0, 32'h0);
        chk("alloc_hit", 64'(hit), 64'(1));
        chk("alloc_way", 64'(hit_way), 64'(0));
        chk("alloc_pred", 64'(pred_taken), 64'(1));
        chk("alloc_target", 64'(pred_target), 64'(32'h400));
        step();

        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 8'h00, 1, 8'h12, 0, 32'h0);
            step();
            drive(0, 1, 8'h12, 0, 8'h00, 0, 32'h0);
            chk("dec_pred", 64'(pred_taken), 64'(0));
            chk("dec_target_kept", 64'(pred_target), 64'(32'h400));
            step();
        end
        drive(0, 0, 8'h00, 1, 8'h12, 1, 32'h404);
        step();
        drive(0, 1, 8'h12, 0, 8'h00, 0, 32'h0);
        chk("sat0_inc_pred", 64'(pred_taken), 64'(0));
        chk("sat0_inc_target", 64'(pred_target), 64'(32'h404));
        step();
        drive(0, 1, 8'h12, 1, 8'h12, 1, 32'h408);
        chk("nobypass_pred", 64'(pred_taken), 64'(0));
        chk("nobypass_target", 64'(pred_target), 64'(32'h404));
        step();
        drive(0, 1, 8'h12, 0, 8'h00, 0, 32'h0);
        chk("inc_pred", 64'(pred_taken), 64'(1));
        chk("inc_target", 64'(pred_target), 64'(32'h408));
        step();

        // Asynchronous reset arriving while an allocation is pending.
        drive(0, 1, 8'h12, 1, 8'h77, 1, 32'h777);
        chk("pre_reset_hit", 64'(hit), 64'(1));
        reset = 1'b1;
        mreset();
        #1;
        chk("async_reset_hit", 64'(hit), 64'(0));
        chk("async_reset_target", 64'(pred_target), 64'(0));
        @(posedge clk);
        #1;
        drive(0, 0, 8'h00, 0, 8'h00, 0, 32'h0);
        reset = 1'b0;
        drive(0, 1, 8'h77, 0, 8'h00, 0, 32'h0);
        chk("dropped_update", 64'(hit), 64'(0));
        step();
        drive(0, 1, 8'h12, 0, 8'h00, 0, 32'h0);
        chk("reset_cleared", 64'(hit), 64'(0));
        step();

        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 8'h00, 1, 8'(8'h0A + k), 1, 32'(32'h1000 + 16 * k));
            step();
        end
        drive(0, 1, 8'h0A, 0, 8'h00, 0, 32'h0);
        step();
        drive(0, 0, 8'h00, 1, 8'h0E, 1, 32'h2000);
        step();
        drive(0, 1, 8'h0E, 0, 8'h00, 0, 32'h0);
        chk("lru_victim_hit", 64'(hit), 64'(1));
        chk("lru_victim_way", 64'(hit_way), 64'(1));
        step();
        drive(0, 1, 8'h0A, 0, 8'h00, 0, 32'h0);
        chk("lru_kept_hit", 64'(hit), 64'(1));
        chk("lru_kept_way", 64'(hit_way), 64'(0));
        step();
        drive(0, 1, 8'h0B, 0, 8'h00, 0, 32'h0);
        chk("lru_evicted", 64'(hit), 64'(0));
        step();

        drive(0, 0, 8'h00, 1, 8'h55, 0, 32'h5555);
        step();
        drive(0, 1, 8'h55, 0, 8'h00, 0, 32'h0);
        chk("nt_miss_noalloc", 64'(hit), 64'(0));
        step();
        drive(0, 1, 8'h0E, 0, 8'h00, 0, 32'h0);
        chk("nt_miss_way", 64'(hit_way), 64'(1));
        step();

        drive(1, 1, 8'h0A, 1, 8'h0A, 1, 32'h3000);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 8'(8'h0A + k), 0, 8'h00, 0, 32'h0);
            chk("flush_miss", 64'(hit), 64'(0));
            step();
        end
        drive(0, 0, 8'h00, 1, 8'h0A, 1, 32'h3100);
        step();
        drive(0, 1, 8'h0A, 0, 8'h00, 0, 32'h0);
        chk("realloc_way", 64'(hit_way), 64'(0));
        chk("realloc_pred", 64'(pred_taken), 64'(1));
        chk("realloc_target", 64'(pred_target), 64'(32'h3100));
        step();
        drive(0, 0, 8'h00, 1, 8'h0A, 0, 32'h0);
        step();
        drive(0, 1, 8'h0A, 0, 8'h00, 0, 32'h0);
        chk("realloc_weak", 64'(pred_taken), 64'(0));
        step();

        for (int n = 0; n < 800; n++) begin
            drive($urandom_range(0, 99) < 3,
                  1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 7)),
                  $urandom_range(0, 99) < 70,
                  8'($urandom_range(0, 7)),
                  $urandom_range(0, 99) < 60,
                  32'($urandom));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bpb_set.md
BPB_SET -- requirements
Module: bpb_set

Interface
REQ-001 SHALL have parameter WAYS, default 4, number of ways; power of two, at least 2.
REQ-002 SHALL have parameter TAG_WIDTH, default 8, stored tag width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, target address width.
REQ-004 SHALL have parameter CTR_BITS, default 2, saturating counter width, at least 1.
REQ-005 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port flush  in  1  invalidate all ways.
REQ-008 SHALL have port lk_en  in  1  lookup valid; a hit refreshes LRU.
REQ-009 SHALL have port lk_tag  in  TAG_WIDTH  lookup tag.
REQ-010 SHALL have port hit  out  1  lk_tag matches a valid way (combinational).
REQ-011 SHALL have port hit_way  out  log2(WAYS)  matching way index, 0 on miss.
REQ-012 SHALL have port pred_taken  out  1  MSB of the hit way's counter, 0 on miss.
REQ-013 SHALL have port pred_target  out  ADDR_WIDTH  hit way's target, 0 on miss.
REQ-014 SHALL have port up_en  in  1  resolved-branch update valid.
REQ-015 SHALL have port up_tag  in  TAG_WIDTH  tag of the resolved branch.
REQ-016 SHALL have port up_taken  in  1  resolved direction.
REQ-017 SHALL have port up_target  in  ADDR_WIDTH  resolved target.

Function
REQ-018 SHALL store per way: valid, tag, target, CTR_BITS counter and log2(WAYS)-bit age; age 0 = MRU, WAYS-1 = LRU, ages always a permutation of 0..WAYS-1.
REQ-019 SHALL, on lookup, match only valid ways; tags unique per set, so at most one way matches.
REQ-020 SHALL, on up_en and up_tag hit: increment the counter when up_taken (saturate at 2^CTR_BITS-1), else decrement (saturate at 0); load target only when up_taken; make the way MRU.
REQ-021 SHALL, on up_en, up_tag miss and up_taken: allocate the lowest-index invalid way, or the LRU way if all are valid; set valid, tag, target; set counter to 2^(CTR_BITS-1) (weakly taken); make the way MRU.
REQ-022 SHALL, on up_en, up_tag miss and ~up_taken: leave all state unchanged.
REQ-023 SHALL make way w MRU as follows: every way with age less than old age(w) increments; w becomes 0; all others unchanged.
REQ-024 SHALL, on lk_en hit, make hit_way MRU next edge.
REQ-025 SHALL, when lookup touch and update touch coincide on different ways, apply the lookup touch first and then the update touch, so the update way ends MRU and the lookup way age 1.
REQ-026 SHALL, when both coincide on the same way, perform a single touch.
REQ-027 SHALL, when an allocation victim equals the lookup hit way, let the allocation win, with the lookup touch applied first.
REQ-028 SHALL give hit/pred outputs zero-cycle latency from lk_tag; updates SHALL be visible on lookup the cycle after the edge.
REQ-029 SHALL give no lookup-to-update bypass: same-cycle lookup sees pre-update state.
REQ-030 SHALL, on flush, clear all valid bits next edge, leaving tag, target, counter and age unchanged.
REQ-031 SHALL give flush priority over up_en and lk_en in the same cycle, with no other change.

Reset
REQ-032 SHALL, on reset assertion and independent of clk, clear valid, tag, target and counter in every way to 0, and set age of way i to i.
REQ-033 SHALL hold hit, hit_way, pred_taken and pred_target at 0 during and after reset until an allocation.
REQ-034 SHALL, when reset asserts mid-update, discard that update entirely.

Verification
REQ-035 SHALL verify reset, then lk_tag=0x00 -> hit=0, hit_way=0, pred_target=0.
REQ-036 SHALL verify up_en, tag 0x12, taken, target 0x400 -> next cycle lookup 0x12: hit=1, way 0, pred_taken=1 (ctr=2), target 0x400.
REQ-037 SHALL verify that three not-taken updates to 0x12 from ctr=2 -> ctr 1, 0, 0 (saturates); pred_taken=0 after the first.
REQ-038 SHALL verify: fill tags 0xA, 0xB, 0xC, 0xD taken, look up 0xA, allocate 0xE -> 0xE replaces way 1 (0xB); 0xA still hits.
REQ-039 SHALL verify a not-taken update to a missing tag 0x55 -> no allocation; lookup 0x55 misses.
REQ-040 SHALL verify flush and up_en on the same edge -> all misses afterward; re-allocate tag 0xA -> way 0, ctr=2.
